dcpu_bus_arbiter: RTL and testbench

DCPU_BUS_ARBITER -- requirements
Module: dcpu_bus_arbiter

---
 rtl/dcpu_pkg.sv | 19 +
 rtl/dcpu_bus_watchdog.sv | 42 ++++
 rtl/dcpu_bus_arbiter.sv | 156 +++++++++++++++
 tb/tb_dcpu_bus_arbiter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/dcpu_pkg.sv
// Shared definitions for the DCPU bus fabric.
// Holds the arbiter state encoding and the default bus-watchdog limit.
package dcpu_pkg;

    // Arbiter ownership states; the numeric values are fixed so that
    // debug probes and other blocks can decode them.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_e;

    // Default bus-watchdog limit in cycles (legal range 1..255).
    localparam int DEFAULT_TIMEOUT_CYCLES = 255;

    // Width of the watchdog stall counter.
    localparam int WDOG_W = 8;

endpackage

// File: rtl/dcpu_bus_watchdog.sv
// Bus watchdog for the DCPU arbiter.
// Counts stalled strobe cycles of the current bus owner and emits a one-cycle
// timeout pulse when the count reaches the configured limit.
module dcpu_bus_watchdog
    import dcpu_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              active,
    input  logic              stall,
    input  logic              clear,
    input  logic [WDOG_W-1:0] limit,
    output logic              timeout
);

    logic [WDOG_W-1:0] count_reg;
    logic [WDOG_W-1:0] count_next;

    // The limit compare is on the registered count, so the pulse appears in
    // the cycle after the last counted stall.
    assign timeout = active && (count_reg == limit);

    // Next count: restart on any completion, on a timeout, or when no owner.
    always_comb begin
        count_next = count_reg;
        if (!active || clear || timeout) begin
            count_next = '0;
        end else if (stall) begin
            count_next = count_reg + 1'b1;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/dcpu_bus_arbiter.sv
// Two-requester Wishbone bus arbiter for the DCPU (m0 = fetcher, m1 = load/store).
// Round-robin on ties, grant held while the owner keeps cyc high, one idle
// cycle between owners. Optional bus watchdog enabled by DCPU_ARB_TIMEOUT_EN.
module dcpu_bus_arbiter
    import dcpu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_m0_addr,
    input  logic [31:0] i_m1_addr,
    input  logic        i_m0_cyc,
    input  logic        i_m1_cyc,
    input  logic [3:0]  i_m0_stb,
    input  logic [3:0]  i_m1_stb,
    input  logic        i_m0_we,
    input  logic        i_m1_we,
    input  logic [31:0] i_m0_dat,
    input  logic [31:0] i_m1_dat,
    output logic [31:0] o_m0_dat,
    output logic [31:0] o_m1_dat,
    output logic        o_m0_ack,
    output logic        o_m1_ack,
    output logic        o_m0_err,
    output logic        o_m1_err,
    output logic [31:0] o_wb_addr,
    output logic        o_wb_cyc,
    output logic [3:0]  o_wb_stb,
    output logic        o_wb_we,
    output logic [31:0] o_wb_dat,
    input  logic [31:0] i_wb_dat,
    input  logic        i_wb_ack,
    input  logic        i_wb_err,
    output logic [1:0]  o_grant
);

    // Reject an out-of-range watchdog limit at elaboration time.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("dcpu_bus_arbiter: TIMEOUT_CYCLES must be in 1..255");
    end

    arb_state_e state_reg;
    arb_state_e state_next;
    // 1 = m1 was granted most recently, 0 = m0.
    logic       last_m1_reg;
    logic       last_m1_next;
    logic       timeout_pulse;

    // Read data is broadcast; only the ack/err qualify it.
    assign o_m0_dat = i_wb_dat;
    assign o_m1_dat = i_wb_dat;

    // State and last-granted registers; reset leaves m1 as last so m0 wins the first tie.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_reg   <= IDLE;
            last_m1_reg <= 1'b1;
        end else begin
            state_reg   <= state_next;
            last_m1_reg <= last_m1_next;
        end
    end

    // Next-state logic: round-robin in IDLE, hold grant while owner's cyc is high.
    always_comb begin
        state_next   = state_reg;
        last_m1_next = last_m1_reg;
        case (state_reg)
            IDLE: begin
                if (i_m0_cyc && (!i_m1_cyc || last_m1_reg)) begin
                    state_next   = GNT0;
                    last_m1_next = 1'b0;
                end else if (i_m1_cyc) begin
                    state_next   = GNT1;
                    last_m1_next = 1'b1;
                end
            end
            GNT0: begin
                if (!i_m0_cyc) begin
                    state_next = IDLE;
                end
            end
            GNT1: begin
                if (!i_m1_cyc) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output mux: bus port driven by the registered owner, responses routed back only to it.
    always_comb begin
        o_wb_addr = '0;
        o_wb_cyc  = 1'b0;
        o_wb_stb  = '0;
        o_wb_we   = 1'b0;
        o_wb_dat  = '0;
        o_grant   = 2'b00;
        o_m0_ack  = 1'b0;
        o_m1_ack  = 1'b0;
        o_m0_err  = 1'b0;
        o_m1_err  = 1'b0;
        case (state_reg)
            GNT0: begin
                o_wb_addr = i_m0_addr;
                o_wb_cyc  = i_m0_cyc;
                o_wb_stb  = i_m0_stb;
                o_wb_we   = i_m0_we;
                o_wb_dat  = i_m0_dat;
                o_grant   = 2'b01;
                o_m0_ack  = i_wb_ack;
                o_m0_err  = i_wb_err || timeout_pulse;
            end
            GNT1: begin
                o_wb_addr = i_m1_addr;
                o_wb_cyc  = i_m1_cyc;
                o_wb_stb  = i_m1_stb;
                o_wb_we   = i_m1_we;
                o_wb_dat  = i_m1_dat;
                o_grant   = 2'b10;
                o_m1_ack  = i_wb_ack;
                o_m1_err  = i_wb_err || timeout_pulse;
            end
            default: begin
            end
        endcase
    end

`ifdef DCPU_ARB_TIMEOUT_EN
    logic wdog_active;
    logic wdog_stall;
    logic wdog_clear;

    assign wdog_active = (state_reg == GNT0) || (state_reg == GNT1);
    assign wdog_stall  = o_wb_cyc && (|o_wb_stb);
    assign wdog_clear  = i_wb_ack || i_wb_err;

    dcpu_bus_watchdog u_watchdog (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .active  (wdog_active),
        .stall   (wdog_stall),
        .clear   (wdog_clear),
        .limit   (WDOG_W'(TIMEOUT_CYCLES)),
        .timeout (timeout_pulse)
    );
`else
    // No watchdog: a stalled slave holds the owner until it responds.
    assign timeout_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_dcpu_bus_arbiter.sv
// Self-checking bench for dcpu_bus_arbiter: directed scenarios followed by
// randomized traffic compared cycle by cycle against a behavioural model.
module tb_dcpu_bus_arbiter;

    localparam int TIMEOUT = 4;
`ifdef DCPU_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic [31:0] i_m0_addr, i_m1_addr, i_m0_dat, i_m1_dat, i_wb_dat;
    logic        i_m0_cyc, i_m1_cyc, i_m0_we, i_m1_we, i_wb_ack, i_wb_err;
    logic [3:0]  i_m0_stb, i_m1_stb;
    logic [31:0] o_m0_dat, o_m1_dat, o_wb_addr, o_wb_dat;
    logic        o_m0_ack, o_m1_ack, o_m0_err, o_m1_err, o_wb_cyc, o_wb_we;
    logic [3:0]  o_wb_stb;
    logic [1:0]  o_grant;

    dcpu_bus_arbiter #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_m0_addr(i_m0_addr), .i_m1_addr(i_m1_addr),
        .i_m0_cyc(i_m0_cyc), .i_m1_cyc(i_m1_cyc),
        .i_m0_stb(i_m0_stb), .i_m1_stb(i_m1_stb),
        .i_m0_we(i_m0_we), .i_m1_we(i_m1_we),
        .i_m0_dat(i_m0_dat), .i_m1_dat(i_m1_dat),
        .o_m0_dat(o_m0_dat), .o_m1_dat(o_m1_dat),
        .o_m0_ack(o_m0_ack), .o_m1_ack(o_m1_ack),
        .o_m0_err(o_m0_err), .o_m1_err(o_m1_err),
        .o_wb_addr(o_wb_addr), .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb),
        .o_wb_we(o_wb_we), .o_wb_dat(o_wb_dat),
        .i_wb_dat(i_wb_dat), .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err),
        .o_grant(o_grant)
    );

    always #5 i_clk = ~i_clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // Model: owner 0 = nobody, 1 = m0, 2 = m1; last = index of last winner.
    int m_owner = 0;
    int m_last  = 1;
    int m_count = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Compare every DUT output with what the model says the current cycle shows.
    task automatic check_outputs();
        logic [31:0] e_addr, e_dat;
        logic [3:0]  e_stb;
        logic [1:0]  e_grant;
        logic        e_cyc, e_we, e_a0, e_a1, e_e0, e_e1, pulse;
        e_addr = '0; e_dat = '0; e_stb = '0; e_grant = 2'b00;
        e_cyc = 1'b0; e_we = 1'b0; e_a0 = 1'b0; e_a1 = 1'b0; e_e0 = 1'b0; e_e1 = 1'b0;
        pulse = TO_EN && (m_owner != 0) && (m_count == TIMEOUT);
        if (m_owner == 1) begin
            e_addr = i_m0_addr; e_dat = i_m0_dat; e_stb = i_m0_stb;
            e_cyc = i_m0_cyc; e_we = i_m0_we; e_grant = 2'b01;
            e_a0 = i_wb_ack; e_e0 = i_wb_err | pulse;
        end else if (m_owner == 2) begin
            e_addr = i_m1_addr; e_dat = i_m1_dat; e_stb = i_m1_stb;
            e_cyc = i_m1_cyc; e_we = i_m1_we; e_grant = 2'b10;
            e_a1 = i_wb_ack; e_e1 = i_wb_err | pulse;
        end
        check_val("grant", {30'd0, o_grant}, {30'd0, e_grant});
        check_val("wb_ctl", {26'd0, o_wb_cyc, o_wb_we, o_wb_stb}, {26'd0, e_cyc, e_we, e_stb});
        check_val("wb_addr", o_wb_addr, e_addr);
        check_val("wb_dat", o_wb_dat, e_dat);
        check_val("resp", {28'd0, o_m0_ack, o_m1_ack, o_m0_err, o_m1_err},
                  {28'd0, e_a0, e_a1, e_e0, e_e1});
        check_val("rd_dat", {o_m0_dat ^ o_m1_dat}, 32'd0);
        check_val("m0_dat", o_m0_dat, i_wb_dat);
    endtask

    // Advance the model across one clock edge using the inputs held before it.
    task automatic model_update();
        logic       own_cyc;
        logic [3:0] own_stb;
        bit         pulse;
        if (i_reset) begin
            m_owner = 0; m_last = 1; m_count = 0;
            return;
        end
        own_cyc = (m_owner == 1) ? i_m0_cyc : (m_owner == 2) ? i_m1_cyc : 1'b0;
        own_stb = (m_owner == 1) ? i_m0_stb : (m_owner == 2) ? i_m1_stb : 4'd0;
        if (TO_EN) begin
            pulse = (m_owner != 0) && (m_count == TIMEOUT);
            if (m_owner == 0 || i_wb_ack || i_wb_err || pulse) m_count = 0;
            else if (own_cyc && own_stb != 4'd0) m_count++;
        end
        case (m_owner)
            0: begin
                if (i_m0_cyc && i_m1_cyc) m_owner = (m_last == 1) ? 1 : 2;
                else if (i_m0_cyc)        m_owner = 1;
                else if (i_m1_cyc)        m_owner = 2;
                if (m_owner != 0) m_last = m_owner - 1;
            end
            1: if (!i_m0_cyc) m_owner = 0;
            2: if (!i_m1_cyc) m_owner = 0;
            default: m_owner = 0;
        endcase
    endtask

    // Inputs are set at posedge+1; check at posedge+2, then cross the next edge.
    task automatic run_cycle();
        #1;
        check_outputs();
        @(posedge i_clk);
        model_update();
        #1;
    endtask

    task automatic clear_inputs();
        i_m0_addr = '0; i_m1_addr = '0; i_m0_dat = '0; i_m1_dat = '0; i_wb_dat = '0;
        i_m0_cyc = 0; i_m1_cyc = 0; i_m0_we = 0; i_m1_we = 0; i_wb_ack = 0; i_wb_err = 0;
        i_m0_stb = '0; i_m1_stb = '0;
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        run_cycle();
        i_reset = 1'b0;
    endtask

    initial begin
        clear_inputs();
        i_reset = 1'b1;
        @(posedge i_clk);
        model_update();
        #1;
        do_reset();
        check_val("reset_grant", {30'd0, o_grant}, 32'd0);
        check_val("reset_cyc", {31'd0, o_wb_cyc}, 32'd0);

        // Single requester grant latency and ack routing.
        $display("[TB] directed: m0 read at 0x100");
        i_m0_cyc = 1; i_m0_addr = 32'h100; i_m0_stb = 4'hF; i_wb_dat = 32'hCAFE_0001;
        run_cycle();
        check_val("lat_cyc", {31'd0, o_wb_cyc}, 32'd1);
        check_val("lat_addr", o_wb_addr, 32'h100);
        check_val("lat_grant", {30'd0, o_grant}, 32'd1);
        i_wb_ack = 1;
        #1;
        check_val("ack_route", {30'd0, o_m0_ack, o_m1_ack}, 32'd2);
        run_cycle();
        i_wb_ack = 0; i_m0_cyc = 0; i_m0_stb = '0;
        run_cycle();
        run_cycle();

        // Tie after reset, idle gap, alternation.
        $display("[TB] directed: tie arbitration");
        do_reset();
        i_m0_cyc = 1; i_m1_cyc = 1; i_m0_addr = 32'h200; i_m1_addr = 32'h300;
        i_m0_stb = 4'h3; i_m1_stb = 4'hC;
        run_cycle();
        check_val("tie_first", {30'd0, o_grant}, 32'd1);
        i_wb_ack = 1;
        #1;
        check_val("m1_no_ack", {31'd0, o_m1_ack}, 32'd0);
        check_val("addr_m0", o_wb_addr, 32'h200);
        i_wb_ack = 0;
        i_m0_cyc = 0;
        run_cycle();
        check_val("gap_idle", {30'd0, o_grant}, 32'd0);
        run_cycle();
        check_val("then_m1", {30'd0, o_grant}, 32'd2);
        i_m1_cyc = 0;
        run_cycle();
        i_m0_cyc = 1; i_m1_cyc = 1;
        run_cycle();
        check_val("tie_again", {30'd0, o_grant}, 32'd1);

        // Reset while m1 owns the bus with an active strobe.
        $display("[TB] directed: reset during GNT1");
        i_m0_cyc = 0;
        run_cycle();
        run_cycle();
        run_cycle();
        check_val("gnt1_held", {30'd0, o_grant}, 32'd2);
        i_reset = 1;
        run_cycle();
        i_reset = 0;
        check_val("rst_cyc", {31'd0, o_wb_cyc}, 32'd0);
        check_val("rst_grant", {30'd0, o_grant}, 32'd0);
        i_m1_cyc = 0; i_m0_cyc = 1;
        run_cycle();
        check_val("post_rst", {30'd0, o_grant}, 32'd1);

        // Stalled owner: watchdog pulse after TIMEOUT stalled cycles, or none without it.
        $display("[TB] directed: stalled slave");
        i_m0_cyc = 0;
        run_cycle();
        run_cycle();
        i_m0_cyc = 1; i_m0_stb = 4'hF;
        run_cycle();
        for (int i = 0; i < TIMEOUT; i++) begin
            check_val("wd_quiet", {31'd0, o_m0_err}, 32'd0);
            run_cycle();
        end
        check_val("wd_pulse", {31'd0, o_m0_err}, {31'd0, TO_EN});
        run_cycle();
        check_val("wd_after", {31'd0, o_m0_err}, 32'd0);
        check_val("wd_grant", {30'd0, o_grant}, 32'd1);
        i_m0_cyc = 0;
        run_cycle();
        run_cycle();

        // Randomized traffic against the model.
        $display("[TB] random: 3000 cycles");
        for (int c = 0; c < 3000; c++) begin
            bit stall_phase;
            stall_phase = ((c / 200) % 2) == 1;
            i_reset   = ($urandom_range(299) == 0);
            i_m0_cyc  = i_m0_cyc ? ($urandom_range(7) != 0) : ($urandom_range(3) == 0);
            i_m1_cyc  = i_m1_cyc ? ($urandom_range(7) != 0) : ($urandom_range(3) == 0);
            i_m0_addr = $urandom; i_m1_addr = $urandom;
            i_m0_dat  = $urandom; i_m1_dat  = $urandom; i_wb_dat = $urandom;
            i_m0_we   = $urandom_range(1); i_m1_we = $urandom_range(1);
            i_m0_stb  = ($urandom_range(3) == 0) ? 4'd0 : 4'($urandom_range(15));
            i_m1_stb  = ($urandom_range(3) == 0) ? 4'd0 : 4'($urandom_range(15));
            i_wb_ack  = stall_phase ? ($urandom_range(19) == 0) : ($urandom_range(3) == 0);
            i_wb_err  = ($urandom_range(31) == 0);
            run_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
